// File: rtl/pipe_ctrl.sv
// Pipeline hazard / memory-wait controller: RUN, WAIT and HALT states.
// Latency: all outputs are combinational decodes of state, flush_pend and the current inputs.
// Backpressure: a data-memory wait freezes every stage, and a timeout halts the core until reset.
// Optional feature macro: PIPE_CTRL_PERF_EN adds the stall_cycles / flush_events counters.
module pipe_ctrl #(
  parameter int unsigned WAIT_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        memwb_bubble,
  output logic        halted,
  output logic        mem_err
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  typedef enum logic [1:0] {RUN, WAIT, HALT} state_t;

  // The last wait cycle allowed before giving up on the memory.
  localparam logic [15:0] TIMEOUT_LAST = 16'(WAIT_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        flush_pend_q, flush_pend_d;
  logic        mem_err_q, mem_err_d;
  logic        freeze;
  logic        load_use;

  // The whole pipeline must hold while the data memory has not answered.
  always_comb begin
    freeze = 1'b0;
    if (state_q == RUN && mem_req && !mem_ready) freeze = 1'b1;
    if (state_q == WAIT && !mem_ready)           freeze = 1'b1;
  end

  // A load in EX that writes a register the ID instruction reads (x0 never counts).
  always_comb begin
    load_use = ex_mem_read && (ex_rd != 5'd0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  end

  // Next-state logic: the memory wait counter, the timeout and the deferred branch flush.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    flush_pend_d = flush_pend_q;
    mem_err_d    = mem_err_q;
    case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          state_d    = WAIT;
          wait_cnt_d = 16'd0;
        end
      end
      WAIT: begin
        if (mem_ready) begin
          state_d = RUN;
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          state_d   = HALT;
          mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
    // A branch resolved during a freeze is remembered and applied when the freeze ends;
    // the first unfrozen cycle always consumes (and clears) the pending flush.
    if (state_q != HALT) begin
      if (freeze) begin
        if (ex_branch_taken) flush_pend_d = 1'b1;
      end else begin
        flush_pend_d = 1'b0;
      end
    end
  end

  // State registers; reset drops any pending flush and the sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      wait_cnt_q   <= 16'd0;
      flush_pend_q <= 1'b0;
      mem_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      flush_pend_q <= flush_pend_d;
      mem_err_q    <= mem_err_d;
    end
  end

  // Output decode in priority order: halt, freeze, flush, load-use stall, normal.
  always_comb begin
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    idex_en      = 1'b0;
    exmem_en     = 1'b0;
    memwb_en     = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    halted       = 1'b0;
    if (!rst_n) begin
      halted = 1'b0;
    end else if (state_q == HALT) begin
      halted = 1'b1;
    end else if (freeze) begin
      memwb_bubble = 1'b1;
    end else begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      if (ex_branch_taken || flush_pend_q) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  assign mem_err = mem_err_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, flush_events_q;

  // Free-running event counters; they wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= 32'd0;
      flush_events_q <= 32'd0;
    end else begin
      if (!pc_en)     stall_cycles_q <= stall_cycles_q + 32'd1;
      if (ifid_flush) flush_events_q <= flush_events_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (WAIT_TIMEOUT=4).
// Output vector order: pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl, bubble, halted, mem_err.
module tb_pipe_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_flush, idex_flush, memwb_bubble, halted, mem_err;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [9:0] V_RESET  = 10'b0000000000;
  localparam logic [9:0] V_NORMAL = 10'b1111100000;
  localparam logic [9:0] V_LDUSE  = 10'b0011101000;
  localparam logic [9:0] V_FREEZE = 10'b0000000100;
  localparam logic [9:0] V_FLUSH  = 10'b1111111000;
  localparam logic [9:0] V_HALT   = 10'b0000000011;

  pipe_ctrl #(.WAIT_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_bubble(memwb_bubble),
    .halted(halted), .mem_err(mem_err)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] outs();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
            ifid_flush, idex_flush, memwb_bubble, halted, mem_err};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    mem_req = 1'b1; ex_branch_taken = 1'b1;
    #2;
    checks++;
    if (outs() !== V_RESET) begin
      errors++; $display("FAIL reset_outputs got %b exp %b", outs(), V_RESET);
    end
    step();
    idle_inputs();
    rst_n = 1'b1;
    #1;
    checks++;
    if (outs() !== V_NORMAL) begin
      errors++; $display("FAIL after_reset_normal got %b exp %b", outs(), V_NORMAL);
    end
    step();
  endtask

  task automatic test_load_use();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    #1;
    checks++;
    if (outs() !== V_LDUSE) begin
      errors++; $display("FAIL load_use_rs1 got %b exp %b", outs(), V_LDUSE);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (outs() !== V_NORMAL) begin
      errors++; $display("FAIL load_use_next got %b exp %b", outs(), V_NORMAL);
    end
    step();
    ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_use_rs2 = 1'b1; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
    #1;
    checks++;
    if (outs() !== V_LDUSE) begin
      errors++; $display("FAIL load_use_rs2 got %b exp %b", outs(), V_LDUSE);
    end
    step();
    id_use_rs2 = 1'b0;
    #1;
    checks++;
    if (outs() !== V_NORMAL) begin
      errors++; $display("FAIL load_use_unused_src got %b exp %b", outs(), V_NORMAL);
    end
    step();
    idle_inputs();
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    #1;
    checks++;
    if (outs() !== V_NORMAL) begin
      errors++; $display("FAIL load_use_x0 got %b exp %b", outs(), V_NORMAL);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_branch();
    ex_branch_taken = 1'b1;
    #1;
    checks++;
    if (outs() !== V_FLUSH) begin
      errors++; $display("FAIL branch_flush got %b exp %b", outs(), V_FLUSH);
    end
    step();
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
    #1;
    checks++;
    if (outs() !== V_FLUSH) begin
      errors++; $display("FAIL branch_over_load_use got %b exp %b", outs(), V_FLUSH);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (outs() !== V_NORMAL) begin
      errors++; $display("FAIL branch_next got %b exp %b", outs(), V_NORMAL);
    end
    step();
  endtask

  task automatic test_freeze();
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      ex_branch_taken = (c == 1);
      #1;
      checks++;
      if (outs() !== V_FREEZE) begin
        errors++; $display("FAIL freeze_cycle%0d got %b exp %b", c, outs(), V_FREEZE);
      end
      step();
    end
    ex_branch_taken = 1'b0;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (outs() !== V_FLUSH) begin
      errors++; $display("FAIL freeze_release_flush got %b exp %b", outs(), V_FLUSH);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (outs() !== V_NORMAL) begin
      errors++; $display("FAIL freeze_after got %b exp %b", outs(), V_NORMAL);
    end
`ifdef PIPE_CTRL_PERF_EN
    checks++;
    if (stall_cycles !== 32'd3) begin
      errors++; $display("FAIL perf_stall_cycles got %0d exp 3", stall_cycles);
    end
    checks++;
    if (flush_events !== 32'd1) begin
      errors++; $display("FAIL perf_flush_events got %0d exp 1", flush_events);
    end
`endif
    step();
  endtask

  task automatic test_timeout();
    mem_req = 1'b1; mem_ready = 1'b0;
    // One RUN freeze cycle, then four WAIT cycles before the halt edge.
    for (int c = 0; c < 5; c++) begin
      ex_branch_taken = (c == 2);
      #1;
      checks++;
      if (outs() !== V_FREEZE) begin
        errors++; $display("FAIL timeout_wait%0d got %b exp %b", c, outs(), V_FREEZE);
      end
      step();
    end
    ex_branch_taken = 1'b0;
    #1;
    checks++;
    if (outs() !== V_HALT) begin
      errors++; $display("FAIL timeout_halt got %b exp %b", outs(), V_HALT);
    end
    mem_ready = 1'b1;
    step();
    checks++;
    if (outs() !== V_HALT) begin
      errors++; $display("FAIL halt_sticky got %b exp %b", outs(), V_HALT);
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if (outs() !== V_RESET) begin
      errors++; $display("FAIL halt_reset got %b exp %b", outs(), V_RESET);
    end
    idle_inputs();
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (outs() !== V_NORMAL) begin
      errors++; $display("FAIL halt_recover got %b exp %b", outs(), V_NORMAL);
    end
    step();
    #1;
    checks++;
    if (outs() !== V_NORMAL) begin
      errors++; $display("FAIL no_pending_after_reset got %b exp %b", outs(), V_NORMAL);
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #3;
    test_reset();
    test_load_use();
    test_branch();
    test_freeze();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
